// File: rtl/cordic_pkg.sv
// Shared constants for the Sobel gradient CORDIC chain:
// octant bit positions, z width and core latency.
package cordic_pkg;

  localparam int OCT_GXNEG = 2;
  localparam int OCT_GYNEG = 1;
  localparam int OCT_SWAP  = 0;

  localparam int ZW_DEF   = 20;
  localparam int T_IR_NUM = 16;

  // one register per micro-rotation plus the input register
  function automatic int core_lat(input int n);
    return n + 1;
  endfunction

  localparam int CORE_LAT_DEF = core_lat(T_IR_NUM);

endpackage

// File: rtl/cordic_pre_fold_if.sv
// Gradient-in / folded-vector-out bundle of cordic_pre_fold.
// master drives din_*, slave (the fold stage) drives dout_* and oct_*.
interface cordic_pre_fold_if #(
  parameter int DW = 16,
  parameter int ZW = 20
);

  logic          din_vsync;
  logic          din_hsync;
  logic [DW-1:0] din_gx;
  logic [DW-1:0] din_gy;
  logic          dout_vsync;
  logic          dout_hsync;
  logic [DW-1:0] dout_x;
  logic [DW-1:0] dout_y;
  logic [ZW-1:0] dout_z;
  logic          oct_valid;
  logic [2:0]    oct_code;

  modport master (
    output din_vsync, din_hsync, din_gx, din_gy,
    input  dout_vsync, dout_hsync, dout_x, dout_y,
    input  dout_z, oct_valid, oct_code
  );

  modport slave (
    input  din_vsync, din_hsync, din_gx, din_gy,
    output dout_vsync, dout_hsync, dout_x, dout_y,
    output dout_z, oct_valid, oct_code
  );

endinterface

// File: rtl/cordic_delay_line.sv
// W-bit x D-deep shift line with synchronous clear, no stall.
// Shared by the pre-fold and post-stage of the CORDIC chain.
module cordic_delay_line #(
  parameter int W = 4,
  parameter int D = 17
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < D; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];

endmodule

// File: rtl/cordic_pre_fold.sv
// Folds signed Gx/Gy into the 0..45 degree sector for cordic_core.
// CORDIC_PRE_SAT_EN: clamp oversize magnitudes instead of truncating.
module cordic_pre_fold
  import cordic_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ZW       = ZW_DEF,
  parameter int CORE_LAT = CORE_LAT_DEF
) (
  input logic              clk,
  input logic              rst,
  cordic_pre_fold_if.slave bus
);

  localparam int MW = DW - 2;
  localparam logic [DW-1:0] MMAX = {2'b00, {MW{1'b1}}};

  // result keeps the top two bits at zero in both builds
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] g);
    logic [DW-1:0] a;
    a = g[DW-1] ? (~g + 1'b1) : g;
`ifdef CORDIC_PRE_SAT_EN
    if (a > MMAX) a = MMAX;
`endif
    return a & MMAX;
  endfunction

  logic          hs1, vs1, gxn, gyn;
  logic [DW-1:0] ax, ay;
  logic          hs2, vs2;
  logic [DW-1:0] x, y;
  logic [2:0]    oct2;
  logic [2:0]    oct_n;
  logic          swap;
  logic [3:0]    head;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      gxn <= 1'b0;
      gyn <= 1'b0;
      ax  <= '0;
      ay  <= '0;
    end else begin
      hs1 <= bus.din_hsync;
      vs1 <= bus.din_vsync;
      if (bus.din_hsync) begin
        gxn <= bus.din_gx[DW-1];
        gyn <= bus.din_gy[DW-1];
        ax  <= mag(bus.din_gx);
        ay  <= mag(bus.din_gy);
      end else begin
        gxn <= 1'b0;
        gyn <= 1'b0;
        ax  <= '0;
        ay  <= '0;
      end
    end
  end

  // ties keep gx on the x axis
  always_comb begin
    swap = ay > ax;
    oct_n = '0;
    oct_n[OCT_GXNEG] = gxn;
    oct_n[OCT_GYNEG] = gyn;
    oct_n[OCT_SWAP]  = swap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs2  <= 1'b0;
      vs2  <= 1'b0;
      x    <= '0;
      y    <= '0;
      oct2 <= '0;
    end else begin
      hs2 <= hs1;
      vs2 <= vs1;
      if (hs1) begin
        x    <= swap ? ay : ax;
        y    <= swap ? ax : ay;
        oct2 <= oct_n;
      end else begin
        x    <= '0;
        y    <= '0;
        oct2 <= '0;
      end
    end
  end

  cordic_delay_line #(
    .W(4),
    .D(CORE_LAT)
  ) u_oct_dly (
    .clk(clk),
    .clr(rst),
    .d  ({hs2, oct2}),
    .q  (head)
  );

  assign bus.dout_vsync = vs2;
  assign bus.dout_hsync = hs2;
  assign bus.dout_x     = x;
  assign bus.dout_y     = y;
  assign bus.dout_z     = '0;
  assign bus.oct_valid  = head[3];
  assign bus.oct_code   = head[3] ? head[2:0] : 3'b000;

endmodule

// File: tb/tb_cordic_pre_fold.sv
// Bench for cordic_pre_fold: directed and random vectors
// against an arithmetic per-edge reference model.
module tb_cordic_pre_fold;
  import cordic_pkg::*;

  localparam int DW   = 16;
  localparam int ZW   = ZW_DEF;
  localparam int CL   = CORE_LAT_DEF;
  localparam int N    = 1024;
  localparam int MMAX = (1 << (DW - 2)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_pre_fold_if #(.DW(DW), .ZW(ZW)) bus ();

  cordic_pre_fold #(
    .DW(DW),
    .ZW(ZW),
    .CORE_LAT(CL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int a_hs [N];
  int a_vs [N];
  int a_gx [N];
  int a_gy [N];
  int e     = 0;
  int lr    = 0;
  int n_vec = 0;
  int n_bad = 0;

  function automatic int fold(input int g);
    int a;
    a = (g < 0) ? -g : g;
`ifdef CORDIC_PRE_SAT_EN
    return (a > MMAX) ? MMAX : a;
`else
    return a % (MMAX + 1);
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s edge %0d: got %0d expected %0d",
             tag, e, obs, exp);
    end
  endtask

  // an input sampled at edge j survives to edge e only if
  // no reset was sampled in [j, e]
  task automatic check_edge();
    int j, k, ax, ay, ex, ey, ev, eh, ec;
    j = e - 1;
    eh = 0; ev = 0; ex = 0; ey = 0;
    if (j >= 1 && lr < j) begin
      ev = a_vs[j];
      if (a_hs[j] != 0) begin
        ax = fold(a_gx[j]);
        ay = fold(a_gy[j]);
        eh = 1;
        ex = (ax >= ay) ? ax : ay;
        ey = (ax >= ay) ? ay : ax;
      end
    end
    chk("dout_vsync", 32'(bus.dout_vsync), ev);
    chk("dout_hsync", 32'(bus.dout_hsync), eh);
    chk("dout_x", 32'(bus.dout_x), ex);
    chk("dout_y", 32'(bus.dout_y), ey);
    chk("dout_z", 32'(bus.dout_z), 0);
    k = e - 1 - CL;
    eh = 0; ec = 0;
    if (k >= 1 && lr < k && a_hs[k] != 0) begin
      ax = fold(a_gx[k]);
      ay = fold(a_gy[k]);
      eh = 1;
      ec = (a_gx[k] < 0 ? 4 : 0) + (a_gy[k] < 0 ? 2 : 0)
         + (ay > ax ? 1 : 0);
    end
    chk("oct_valid", 32'(bus.oct_valid), eh);
    chk("oct_code", 32'(bus.oct_code), ec);
  endtask

  task automatic cyc(input bit r, input bit vs, input bit hs,
                     input int gx, input int gy);
    @(negedge clk);
    rst = r;
    bus.din_vsync = vs;
    bus.din_hsync = hs;
    bus.din_gx = gx[DW-1:0];
    bus.din_gy = gy[DW-1:0];
    @(posedge clk);
    e++;
    a_hs[e] = int'(hs);
    a_vs[e] = int'(vs);
    a_gx[e] = gx;
    a_gy[e] = gy;
    if (r) lr = e;
    #1 check_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  function automatic int rnd_g();
    logic [DW-1:0] r;
    int sel;
    sel = int'($urandom_range(0, 9));
    r = DW'($urandom);
    case (sel)
      0: return -32768;
      1: return 32767;
      2: return 0;
      3: return int'($signed(r)) / 4;
      default: return int'($signed(r));
    endcase
  endfunction

  initial begin
    bus.din_vsync = 1'b0;
    bus.din_hsync = 1'b0;
    bus.din_gx = '0;
    bus.din_gy = '0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 0, 0);

    cyc(1'b0, 1'b1, 1'b1, 112, 16);
    idle(CL + 3);
    cyc(1'b0, 1'b1, 1'b1, -16, 112);
    cyc(1'b0, 1'b1, 1'b1, -50, -50);
    cyc(1'b0, 1'b1, 1'b1, -32768, 0);
    cyc(1'b0, 1'b1, 1'b1, 20000, -20000);
    cyc(1'b0, 1'b1, 1'b1, 32767, -32767);
    cyc(1'b0, 1'b1, 1'b1, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 3, -7);
    idle(CL + 3);

    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b1, rnd_g(), rnd_g());
    idle(CL + 3);

    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 1'b0, 1234, -555);
    idle(CL + 3);

    cyc(1'b0, 1'b1, 1'b1, 9, -300);
    cyc(1'b0, 1'b1, 1'b1, -77, 5);
    cyc(1'b0, 1'b1, 1'b1, 400, 400);
    cyc(1'b1, 1'b1, 1'b1, 11, 22);
    idle(CL + 4);
    cyc(1'b0, 1'b1, 1'b1, -16, 112);
    idle(CL + 3);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 39) == 0, 1'($urandom),
          $urandom_range(0, 3) != 0, rnd_g(), rnd_g());
    idle(CL + 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
